// File: rtl/inst_fetch_unit.sv
// Instruction-fetch stage: PC register, instruction memory with boot-time load port,
// field decode and an IDLE/RUN/HALT sequencer that gates fetch.
module inst_fetch_unit #(
  parameter int IMEM_DEPTH = 64,
  parameter int COUNT_W    = 32
) (
  input  logic                          CLK,
  input  logic                          Reset,
  input  logic                          PCWre,
  input  logic                          PCSrc,
  input  logic                          load_en,
  input  logic [$clog2(IMEM_DEPTH)-1:0] load_addr,
  input  logic [31:0]                   load_data,
  input  logic                          start,
  output logic [31:0]                   PC,
  output logic [31:0]                   nextPC,
  output logic [31:0]                   instruction,
  output logic [5:0]                    opCode,
  output logic [4:0]                    rs,
  output logic [4:0]                    rt,
  output logic [4:0]                    rd,
  output logic [15:0]                   immediate,
  output logic                          running,
  output logic                          halted,
  output logic [COUNT_W-1:0]            instr_count
);

  localparam int          AW        = $clog2(IMEM_DEPTH);
  localparam logic [31:0] HALT_WORD = 32'hFC00_0000;
  localparam logic [31:0] PC_LIMIT  = 32'(4 * IMEM_DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] mem [IMEM_DEPTH];
  logic        in_range;
  logic [31:0] branch_off;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q     <= IDLE;
      PC          <= 32'd0;
      instr_count <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == RUN && PCWre) begin
        PC          <= nextPC;
        instr_count <= instr_count + COUNT_W'(1);
      end
    end
  end

  // Program memory is never cleared, so a fresh start after Reset replays it.
  always_ff @(posedge CLK) begin
    if (!Reset && state_q == IDLE && load_en)
      mem[load_addr] <= load_data;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (!PCWre) state_d = HALT;
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  // Outside RUN, or past the end of memory, the halt opcode is fed downstream.
  assign in_range    = (PC < PC_LIMIT);
  assign instruction = (state_q == RUN && in_range) ? mem[PC[AW+1:2]] : HALT_WORD;

  assign opCode    = instruction[31:26];
  assign rs        = instruction[25:21];
  assign rt        = instruction[20:16];
  assign rd        = instruction[15:11];
  assign immediate = instruction[15:0];

  assign branch_off = PCSrc ? {{14{immediate[15]}}, immediate, 2'b00} : 32'd0;
  assign nextPC     = PC + 32'd4 + branch_off;

  assign running = (state_q == RUN);
  assign halted  = (state_q == HALT);

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: a mode/PC/count model checked on every negedge,
// plus literal expectations at the key points of each scenario.
module tb_inst_fetch_unit;
  localparam int DEPTH = 4;
  localparam int CW    = 32;

  logic          CLK = 1'b0;
  logic          Reset = 1'b1;
  logic          PCWre = 1'b0;
  logic          PCSrc = 1'b0;
  logic          load_en = 1'b0;
  logic [1:0]    load_addr = 2'd0;
  logic [31:0]   load_data = 32'd0;
  logic          start = 1'b0;
  logic [31:0]   PC, nextPC, instruction;
  logic [5:0]    opCode;
  logic [4:0]    rs, rt, rd;
  logic [15:0]   immediate;
  logic          running, halted;
  logic [CW-1:0] instr_count;

  inst_fetch_unit #(.IMEM_DEPTH(DEPTH), .COUNT_W(CW)) dut (
    .CLK(CLK), .Reset(Reset), .PCWre(PCWre), .PCSrc(PCSrc),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data), .start(start),
    .PC(PC), .nextPC(nextPC), .instruction(instruction), .opCode(opCode),
    .rs(rs), .rt(rt), .rd(rd), .immediate(immediate),
    .running(running), .halted(halted), .instr_count(instr_count)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Model: mode 0 = waiting for start, 1 = fetching, 2 = stopped.
  int          mode = 0;
  logic [31:0] mpc = 32'd0;
  logic [31:0] mcnt = 32'd0;
  logic [31:0] m [DEPTH];

  function automatic logic [31:0] m_instr();
    if (mode == 1 && mpc < 32'(4 * DEPTH)) return m[mpc >> 2];
    return 32'hFC00_0000;
  endfunction

  function automatic logic [31:0] m_next();
    logic [31:0] w;
    int off;
    w = m_instr();
    off = PCSrc ? 4 * int'($signed(w[15:0])) : 0;
    return mpc + 32'd4 + 32'(off);
  endfunction

  always @(posedge CLK) begin
    if (Reset) begin
      mode = 0; mpc = 32'd0; mcnt = 32'd0;
    end else if (mode == 0) begin
      if (load_en) m[load_addr] = load_data;
      if (start) mode = 1;
    end else if (mode == 1) begin
      if (PCWre) begin
        mpc = m_next();
        mcnt = mcnt + 32'd1;
      end else mode = 2;
    end
  end

  always @(negedge CLK) begin
    logic [31:0] w;
    w = m_instr();
    chk("pc", PC, mpc);
    chk("next_pc", nextPC, m_next());
    chk("instruction", instruction, w);
    chk("opcode", 32'(opCode), 32'(w[31:26]));
    chk("rs", 32'(rs), 32'(w[25:21]));
    chk("rt", 32'(rt), 32'(w[20:16]));
    chk("rd", 32'(rd), 32'(w[15:11]));
    chk("immediate", 32'(immediate), 32'(w[15:0]));
    chk("running", 32'(running), 32'(mode == 1));
    chk("halted", 32'(halted), 32'(mode == 2));
    chk("instr_count", instr_count, mcnt);
  end

  // Drive one cycle; PCWre emulates the control unit (stall on the halt opcode).
  task automatic drive(input logic ld, input logic [1:0] la, input logic [31:0] d,
                       input logic st, input logic src);
    load_en = ld; load_addr = la; load_data = d; start = st; PCSrc = src;
    PCWre = (opCode != 6'h3F);
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    drive(1'b0, 2'd0, 32'd0, 1'b0, 1'b0);
    Reset = 1'b0;
  endtask

  initial begin
    @(posedge CLK);
    #1;
    chk("reset_pc", PC, 32'd0);
    chk("reset_instr", instruction, 32'hFC00_0000);
    chk("reset_running", 32'(running), 32'd0);
    chk("reset_halted", 32'(halted), 32'd0);
    chk("reset_count", instr_count, 32'd0);
    Reset = 1'b0;

    // Three-word program ending in the halt opcode; loads during RUN/HALT must be dropped.
    drive(1'b1, 2'd0, 32'h0421_0001, 1'b0, 1'b0);
    drive(1'b1, 2'd1, 32'h0000_0000, 1'b0, 1'b0);
    drive(1'b1, 2'd2, 32'hFC00_0000, 1'b0, 1'b0);
    drive(1'b0, 2'd0, 32'd0, 1'b1, 1'b0);
    chk("a_running", 32'(running), 32'd1);
    chk("a_op0", 32'(opCode), 32'h01);
    drive(1'b1, 2'd0, 32'h1234_5678, 1'b0, 1'b0);
    chk("a_pc4", PC, 32'd4);
    chk("a_op1", 32'(opCode), 32'h00);
    drive(1'b1, 2'd1, 32'h1234_5678, 1'b0, 1'b0);
    chk("a_pc8", PC, 32'd8);
    chk("a_op2", 32'(opCode), 32'h3F);
    drive(1'b1, 2'd0, 32'h1234_5678, 1'b0, 1'b0);
    chk("a_halted", 32'(halted), 32'd1);
    chk("a_count", instr_count, 32'd2);
    drive(1'b1, 2'd0, 32'h1234_5678, 1'b1, 1'b0);
    chk("a_pc_hold", PC, 32'd8);

    // Replay after reset shows the original words.
    do_reset();
    drive(1'b0, 2'd0, 32'd0, 1'b1, 1'b0);
    chk("b_word0", instruction, 32'h0421_0001);
    drive(1'b0, 2'd0, 32'd0, 1'b0, 1'b0);
    chk("b_word1", instruction, 32'h0000_0000);
    drive(1'b0, 2'd0, 32'd0, 1'b0, 1'b0);
    drive(1'b0, 2'd0, 32'd0, 1'b0, 1'b0);
    chk("b_count", instr_count, 32'd2);

    // Load/start collision, branch taken and not taken, then reset mid-run.
    do_reset();
    drive(1'b1, 2'd2, 32'hC000_FFFE, 1'b0, 1'b0);
    drive(1'b1, 2'd3, 32'h0000_0000, 1'b0, 1'b0);
    drive(1'b1, 2'd0, 32'h0800_0000, 1'b1, 1'b0);
    chk("c_collision_op", 32'(opCode), 32'h02);
    drive(1'b0, 2'd0, 32'd0, 1'b0, 1'b0);
    drive(1'b0, 2'd0, 32'd0, 1'b0, 1'b0);
    chk("c_branch_instr", instruction, 32'hC000_FFFE);
    PCSrc = 1'b1;
    #1;
    chk("c_branch_next", nextPC, 32'd4);
    drive(1'b0, 2'd0, 32'd0, 1'b0, 1'b1);
    chk("c_taken_pc", PC, 32'd4);
    drive(1'b0, 2'd0, 32'd0, 1'b0, 1'b0);
    drive(1'b0, 2'd0, 32'd0, 1'b0, 1'b0);
    chk("c_not_taken_pc", PC, 32'd12);
    chk("c_count", instr_count, 32'd5);
    do_reset();
    chk("c_rst_pc", PC, 32'd0);
    chk("c_rst_running", 32'(running), 32'd0);
    chk("c_rst_count", instr_count, 32'd0);
    chk("c_rst_instr", instruction, 32'hFC00_0000);

    // Four non-halt words: fetch runs off the end and halts on the out-of-range word.
    drive(1'b0, 2'd0, 32'd0, 1'b1, 1'b0);
    chk("d_replay_op", 32'(opCode), 32'h02);
    for (int i = 0; i < 4; i++) drive(1'b0, 2'd0, 32'd0, 1'b0, 1'b0);
    chk("d_pc16", PC, 32'd16);
    chk("d_oob_instr", instruction, 32'hFC00_0000);
    drive(1'b0, 2'd0, 32'd0, 1'b0, 1'b0);
    chk("d_halted", 32'(halted), 32'd1);
    chk("d_count", instr_count, 32'd4);
    drive(1'b0, 2'd0, 32'd0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
